// File: rtl/ins_pkg.sv
// Shared definitions for the instruction encoder: one-hot request bit positions,
// 4-bit opcodes, writer FSM encoding and the byte packing helper.
package ins_pkg;

  localparam int OP_MOVA = 0;
  localparam int OP_MOVB = 1;
  localparam int OP_MOVC = 2;
  localparam int OP_MOVD = 3;
  localparam int OP_ADD  = 4;
  localparam int OP_SUB  = 5;
  localparam int OP_JMP  = 6;
  localparam int OP_JG   = 7;
  localparam int OP_IN1  = 8;
  localparam int OP_OUT1 = 9;
  localparam int OP_MOVI = 10;
  localparam int OP_HALT = 11;
  localparam int NUM_OPS = 12;

  localparam logic [3:0] OPC_MOVA = 4'b0100;
  localparam logic [3:0] OPC_MOVB = 4'b0101;
  localparam logic [3:0] OPC_MOVC = 4'b0110;
  localparam logic [3:0] OPC_MOVD = 4'b0111;
  localparam logic [3:0] OPC_ADD  = 4'b1000;
  localparam logic [3:0] OPC_SUB  = 4'b1001;
  localparam logic [3:0] OPC_JMP  = 4'b1010;
  localparam logic [3:0] OPC_JG   = 4'b1011;
  localparam logic [3:0] OPC_IN1  = 4'b0000;
  localparam logic [3:0] OPC_OUT1 = 4'b0001;
  localparam logic [3:0] OPC_MOVI = 4'b0010;
  localparam logic [3:0] OPC_HALT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_OP  = 2'd1,
    ST_WR_IMM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [7:0] pack_insn(input logic [3:0] opc, input logic [1:0] rs,
                                           input logic [1:0] rd);
    return {opc, rs, rd};
  endfunction

endpackage

// File: rtl/ins_op_map.sv
// Combinational decode of the one-hot request into opcode and per-op attributes.
// Anything that is not exactly one-hot maps to is_onehot=0 with all attributes cleared.
module ins_op_map
  import ins_pkg::*;
(
  input  logic [NUM_OPS-1:0] op,
  output logic [3:0]         opcode,
  output logic               is_onehot,
  output logic               two_byte,
  output logic               is_halt
);

  // One-hot to opcode lookup; illegal patterns fall to the default arm.
  always_comb begin
    opcode    = 4'b0000;
    is_onehot = 1'b1;
    two_byte  = 1'b0;
    is_halt   = 1'b0;
    case (op)
      (12'd1 << OP_MOVA): opcode = OPC_MOVA;
      (12'd1 << OP_MOVB): opcode = OPC_MOVB;
      (12'd1 << OP_MOVC): opcode = OPC_MOVC;
      (12'd1 << OP_MOVD): opcode = OPC_MOVD;
      (12'd1 << OP_ADD):  opcode = OPC_ADD;
      (12'd1 << OP_SUB):  opcode = OPC_SUB;
      (12'd1 << OP_JMP):  begin opcode = OPC_JMP;  two_byte = 1'b1; end
      (12'd1 << OP_JG):   begin opcode = OPC_JG;   two_byte = 1'b1; end
      (12'd1 << OP_IN1):  opcode = OPC_IN1;
      (12'd1 << OP_OUT1): opcode = OPC_OUT1;
      (12'd1 << OP_MOVI): begin opcode = OPC_MOVI; two_byte = 1'b1; end
      (12'd1 << OP_HALT): begin opcode = OPC_HALT; is_halt  = 1'b1; end
      default:            is_onehot = 1'b0;
    endcase
  end

endmodule

// File: rtl/ins_encode.sv
// Program writer: encodes one mnemonic request per handshake and writes it to program RAM.
// Define INS_ENCODE_CHECKSUM_EN to add chk_xor, a running XOR of every byte written.
module ins_encode
  import ins_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [NUM_OPS-1:0]  req_op,
  input  logic [1:0]          req_rs,
  input  logic [1:0]          req_rd,
  input  logic [7:0]          req_imm,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [ADDR_W:0]     wr_count,
  output logic                done,
  output logic                full,
  output logic                err
`ifdef INS_ENCODE_CHECKSUM_EN
  ,
  output logic [7:0]          chk_xor
`endif
);

  if (DATA_W != 8) begin : g_data_w_check
    $error("ins_encode: DATA_W must be 8");
  end

  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W:0]     wr_count_r;
  logic [7:0]          op_byte_r, imm_r;
  logic                two_byte_r, halt_r;
  logic                done_r, full_r, err_r, armed_r;
  logic [3:0]          opcode_s;
  logic                onehot_s, two_byte_s, halt_s;
  logic                hs_s, reject_s, we_s, ready_s;
  logic [7:0]          wdata_s;

  ins_op_map u_op_map (
    .op        (req_op),
    .opcode    (opcode_s),
    .is_onehot (onehot_s),
    .two_byte  (two_byte_s),
    .is_halt   (halt_s)
  );

  assign hs_s     = req_valid & ready_s;
  // A two-byte op needs addr and addr+1 both inside RAM, so the last slot is not enough.
  assign reject_s = ~onehot_s | (two_byte_s & (addr_r == ADDR_MAX));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic; start overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (start) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = (hs_s && !reject_s) ? ST_WR_OP : ST_IDLE;
        ST_WR_OP:  state_nxt_s = two_byte_r ? ST_WR_IMM : (halt_r ? ST_DONE : ST_IDLE);
        ST_WR_IMM: state_nxt_s = ST_IDLE;
        ST_DONE:   state_nxt_s = ST_DONE;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output decode from the registered state; start masks the write strobe.
  always_comb begin
    we_s    = 1'b0;
    wdata_s = op_byte_r;
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE:   ready_s = armed_r & ~done_r & ~full_r & ~start;
      ST_WR_OP:  we_s = ~start;
      ST_WR_IMM: begin we_s = ~start; wdata_s = imm_r; end
      ST_DONE:   ready_s = 1'b0;
      default:   we_s = 1'b0;
    endcase
  end

  // Datapath: request capture, address, counters and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r     <= '0;
      wr_count_r <= '0;
      op_byte_r  <= 8'h00;
      imm_r      <= 8'h00;
      two_byte_r <= 1'b0;
      halt_r     <= 1'b0;
      done_r     <= 1'b0;
      full_r     <= 1'b0;
      err_r      <= 1'b0;
      armed_r    <= 1'b0;
    end else if (start) begin
      addr_r     <= '0;
      wr_count_r <= '0;
      done_r     <= 1'b0;
      full_r     <= 1'b0;
      err_r      <= 1'b0;
      armed_r    <= 1'b1;
    end else begin
      armed_r <= 1'b1;
      err_r   <= hs_s & reject_s;
      if (hs_s && !reject_s) begin
        op_byte_r  <= pack_insn(opcode_s, req_rs, req_rd);
        imm_r      <= req_imm;
        two_byte_r <= two_byte_s;
        halt_r     <= halt_s;
      end
      if (we_s) begin
        addr_r <= addr_r + ADDR_W'(1);
        if (addr_r == ADDR_MAX) full_r <= 1'b1;
        if (wr_count_r != DEPTH) wr_count_r <= wr_count_r + (ADDR_W+1)'(1);
        if (state_r == ST_WR_OP && halt_r) done_r <= 1'b1;
      end
    end
  end

`ifdef INS_ENCODE_CHECKSUM_EN
  logic [7:0] chk_r;

  // Running XOR of written bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      chk_r <= 8'h00;
    else if (start)  chk_r <= 8'h00;
    else if (we_s)   chk_r <= chk_r ^ wdata_s;
  end

  assign chk_xor = chk_r;
`endif

  assign req_ready = ready_s;
  assign mem_we    = we_s;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_s;
  assign wr_count  = wr_count_r;
  assign done      = done_r;
  assign full      = full_r;
  assign err       = err_r;

endmodule

// File: tb/tb_ins_encode.sv
// Directed bench for ins_encode: one 256-byte instance (a) and one 4-byte instance (b)
// sharing request fields; tgt selects which instance sees req_valid.
module tb_ins_encode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        req_valid = 1'b0;
  logic [11:0] req_op = 12'h000;
  logic [1:0]  req_rs = 2'd0, req_rd = 2'd0;
  logic [7:0]  req_imm = 8'h00;
  logic        tgt = 1'b0;

  logic        ready_a, we_a, done_a, full_a, err_a;
  logic [7:0]  addr_a, wdata_a;
  logic [8:0]  cnt_a;
  logic        ready_b, we_b, done_b, full_b, err_b;
  logic [1:0]  addr_b;
  logic [7:0]  wdata_b;
  logic [2:0]  cnt_b;
`ifdef INS_ENCODE_CHECKSUM_EN
  logic [7:0]  chk_a, chk_b;
`endif

  logic valid_a, valid_b, ready_t, err_t;
  assign valid_a = req_valid & ~tgt;
  assign valid_b = req_valid & tgt;
  assign ready_t = tgt ? ready_b : ready_a;
  assign err_t   = tgt ? err_b : err_a;

  always #5 clk = ~clk;

  ins_encode #(.ADDR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(valid_a), .req_ready(ready_a),
    .req_op(req_op), .req_rs(req_rs), .req_rd(req_rd), .req_imm(req_imm),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .wr_count(cnt_a),
    .done(done_a), .full(full_a), .err(err_a)
`ifdef INS_ENCODE_CHECKSUM_EN
    , .chk_xor(chk_a)
`endif
  );

  ins_encode #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(valid_b), .req_ready(ready_b),
    .req_op(req_op), .req_rs(req_rs), .req_rd(req_rd), .req_imm(req_imm),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .wr_count(cnt_b),
    .done(done_b), .full(full_b), .err(err_b)
`ifdef INS_ENCODE_CHECKSUM_EN
    , .chk_xor(chk_b)
`endif
  );

  // Write logs: {address, data} for every strobe seen.
  logic [15:0] log_a[$];
  logic [15:0] log_b[$];
  always @(negedge clk) begin
    if (we_a) log_a.push_back({addr_a, wdata_a});
    if (we_b) log_b.push_back({6'd0, addr_b, wdata_b});
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] log_at(input int which, input int idx);
    if (which == 0) return (idx < log_a.size()) ? log_a[idx] : 16'hDEAD;
    else            return (idx < log_b.size()) ? log_b[idx] : 16'hDEAD;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    log_a.delete();
    log_b.delete();
  endtask

  // Present a request, wait (bounded) for the handshake, return err seen one cycle later.
  task automatic issue(input logic [11:0] op, input logic [1:0] rs, input logic [1:0] rd,
                       input logic [7:0] imm, output logic e);
    bit got = 1'b0;
    @(negedge clk);
    req_op = op; req_rs = rs; req_rd = rd; req_imm = imm; req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (ready_t) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      n_vec++; n_fail++;
      $display("FAIL handshake: req_ready never rose for op %h", op);
      req_valid = 1'b0; e = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    e = err_t;
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic [11:0] op;
    logic [1:0]  rs, rd;
    logic [7:0]  imm;
    logic        exp_err;
    int          exp_n;
    logic [7:0]  exp_b0, exp_b1;
    logic        exp_done;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic e;
    vt[0]  = '{12'h001, 2'd0, 2'd1, 8'hFF, 1'b0, 1, 8'h41, 8'h00, 1'b0};
    vt[1]  = '{12'h002, 2'd1, 2'd2, 8'hFF, 1'b0, 1, 8'h56, 8'h00, 1'b0};
    vt[2]  = '{12'h004, 2'd2, 2'd3, 8'h00, 1'b0, 1, 8'h6B, 8'h00, 1'b0};
    vt[3]  = '{12'h008, 2'd3, 2'd0, 8'h11, 1'b0, 1, 8'h7C, 8'h00, 1'b0};
    vt[4]  = '{12'h010, 2'd1, 2'd2, 8'h00, 1'b0, 1, 8'h86, 8'h00, 1'b0};
    vt[5]  = '{12'h020, 2'd2, 2'd1, 8'h00, 1'b0, 1, 8'h99, 8'h00, 1'b0};
    vt[6]  = '{12'h040, 2'd0, 2'd0, 8'h00, 1'b0, 2, 8'hA0, 8'h00, 1'b0};
    vt[7]  = '{12'h080, 2'd1, 2'd3, 8'hC3, 1'b0, 2, 8'hB7, 8'hC3, 1'b0};
    vt[8]  = '{12'h100, 2'd0, 2'd0, 8'h77, 1'b0, 1, 8'h00, 8'h00, 1'b0};
    vt[9]  = '{12'h200, 2'd3, 2'd3, 8'h00, 1'b0, 1, 8'h1F, 8'h00, 1'b0};
    vt[10] = '{12'h400, 2'd0, 2'd3, 8'h5A, 1'b0, 2, 8'h23, 8'h5A, 1'b0};
    vt[11] = '{12'h800, 2'd0, 2'd0, 8'h00, 1'b0, 1, 8'h30, 8'h00, 1'b1};
    vt[12] = '{12'h0C0, 2'd1, 2'd1, 8'h12, 1'b1, 0, 8'h00, 8'h00, 1'b0};
    vt[13] = '{12'h000, 2'd0, 2'd0, 8'h00, 1'b1, 0, 8'h00, 8'h00, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_a_outs", {ready_a, we_a, addr_a, wdata_a, cnt_a, done_a, full_a, err_a}, 32'd0);
    chk("reset_b_outs", {ready_b, we_b, addr_b, wdata_b, cnt_b, done_b, full_b, err_b}, 32'd0);
    rst_n = 1'b1;

    // Single-request vectors, each from a fresh start
    foreach (vt[i]) begin
      pulse_start();
      issue(vt[i].op, vt[i].rs, vt[i].rd, vt[i].imm, e);
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("v%0d_err", i), e, vt[i].exp_err);
      chk($sformatf("v%0d_nwr", i), log_a.size(), vt[i].exp_n);
      if (vt[i].exp_n >= 1) chk($sformatf("v%0d_b0", i), log_at(0, 0), {8'h00, vt[i].exp_b0});
      if (vt[i].exp_n == 2) chk($sformatf("v%0d_b1", i), log_at(0, 1), {8'h01, vt[i].exp_b1});
      chk($sformatf("v%0d_cnt", i), cnt_a, vt[i].exp_n);
      chk($sformatf("v%0d_done", i), done_a, vt[i].exp_done);
      chk($sformatf("v%0d_ready", i), ready_a, !vt[i].exp_done);
      chk($sformatf("v%0d_err_clr", i), err_a, 1'b0);
    end

    // movi: req_ready low for exactly two cycles after the handshake
    pulse_start();
    issue(12'h400, 2'd0, 2'd3, 8'h5A, e);
    chk("movi_rdy_c1", ready_a, 1'b0);
    @(negedge clk);
    chk("movi_rdy_c2", ready_a, 1'b0);
    @(negedge clk);
    chk("movi_rdy_c3", ready_a, 1'b1);
    chk("movi_log", {log_at(0, 0), log_at(0, 1)}, 32'h0023_015A);

    // in1, jmp 0x00, halt back to back, then start clears done
    pulse_start();
    issue(12'h100, 2'd0, 2'd0, 8'h00, e);
    issue(12'h040, 2'd0, 2'd0, 8'h00, e);
    issue(12'h800, 2'd0, 2'd0, 8'h00, e);
    repeat (2) @(negedge clk);
    chk("seq_n", log_a.size(), 4);
    chk("seq_w01", {log_at(0, 0), log_at(0, 1)}, 32'h0000_01A0);
    chk("seq_w23", {log_at(0, 2), log_at(0, 3)}, 32'h0200_0330);
    chk("seq_done", done_a, 1'b1);
    chk("seq_ready", ready_a, 1'b0);
    chk("seq_cnt", cnt_a, 9'd4);
`ifdef INS_ENCODE_CHECKSUM_EN
    chk("seq_chk_xor", chk_a, 8'h90);
`endif
    pulse_start();
    #1;
    chk("start_clr_done", done_a, 1'b0);
    chk("start_ready", ready_a, 1'b1);

    // Rejection keeps count and writes unchanged; err is a single pulse
    issue(12'h010, 2'd1, 2'd2, 8'h00, e);
    issue(12'h0C0, 2'd0, 2'd0, 8'h00, e);
    chk("rej_err", e, 1'b1);
    chk("rej_no_we", we_a, 1'b0);
    @(negedge clk);
    chk("rej_err_pulse", err_a, 1'b0);
    chk("rej_cnt", cnt_a, 9'd1);
    chk("rej_n", log_a.size(), 1);

    // 4-byte instance: jg rejected at last slot, single-byte op fills RAM
    tgt = 1'b1;
    pulse_start();
    issue(12'h010, 2'd1, 2'd2, 8'h00, e);
    issue(12'h010, 2'd1, 2'd2, 8'h00, e);
    issue(12'h010, 2'd1, 2'd2, 8'h00, e);
    issue(12'h080, 2'd1, 2'd3, 8'hC3, e);
    chk("b_jg_err", e, 1'b1);
    @(negedge clk);
    chk("b_jg_n", log_b.size(), 3);
    issue(12'h200, 2'd3, 2'd3, 8'h00, e);
    @(negedge clk);
    chk("b_n", log_b.size(), 4);
    chk("b_last", log_at(1, 3), 16'h031F);
    chk("b_full", full_b, 1'b1);
    chk("b_ready", ready_b, 1'b0);
    chk("b_cnt", cnt_b, 3'd4);
    chk("b_addr", addr_b, 2'd0);
    pulse_start();
    #1;
    chk("b_start_full", full_b, 1'b0);
    chk("b_start_ready", ready_b, 1'b1);
    tgt = 1'b0;

    // Reset during WR_IMM of a jg aborts the imm write
    pulse_start();
    @(negedge clk);
    req_op = 12'h080; req_rs = 2'd1; req_rd = 2'd3; req_imm = 8'hC3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {ready_a, we_a, addr_a, wdata_a, cnt_a, done_a, full_a, err_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_n", log_a.size(), 1);
    chk("rst_mid_b0", log_at(0, 0), 16'h00B7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
